multicycle_alu: RTL and testbench

//  Parametrised successor of the single-cycle RV32 ALU: registered, handshaked execution unit.
//  - Single-cycle ops (ADD..SLTU) complete in 1 cycle.
//  - Iterative ops (MUL, MULHU, DIVU, REMU) take DATA_WIDTH step cycles.
//  - Sits in the EX stage; the core's stall logic watches ready_o.

---
 rtl/multicycle_alu_pkg.sv | 34 +++
 rtl/multicycle_alu_muldiv_iter.sv | 72 +++++++
 rtl/multicycle_alu.sv | 120 ++++++++++++
 tb/tb_multicycle_alu.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_alu_pkg.sv
// Shared opcode encodings and FSM state type for the multicycle ALU.
// The top level and the instruction decoder both use these encodings.
package multicycle_alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_XOR   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRA   = 4'b0110;
  localparam logic [3:0] OP_SRL   = 4'b0111;
  localparam logic [3:0] OP_ORI   = 4'b1000;
  localparam logic [3:0] OP_LUI   = 4'b1001;
  localparam logic [3:0] OP_SLT   = 4'b1010;
  localparam logic [3:0] OP_SLTU  = 4'b1011;
  localparam logic [3:0] OP_MUL   = 4'b1100;
  localparam logic [3:0] OP_MULHU = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_REMU  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // 11xx opcodes run on the iterative unit; bit 1 picks divide, bit 0 the upper half.
  function automatic logic is_iter(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

endpackage

// File: rtl/multicycle_alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one 2W accumulator.
// go loads the operands; done flags the final step, with result showing that step's outcome.
module multicycle_alu_muldiv_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go,
  input  logic         abort,
  input  logic         is_div,
  input  logic         hi_sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         div0
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0]  count;
  logic [2*W-1:0] acc;
  logic [W-1:0]   b_q;
  logic           div_q;
  logic           hi_q;

  logic [W:0]     mul_sum;
  logic [W:0]     rem_sh;
  logic [W-1:0]   rem_diff;
  logic           fits;
  logic [2*W-1:0] acc_next;

  // Multiply: {hi, lo} accumulates into hi and shifts right; divide: {rem, quo} shifts left.
  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_q} : '0);
    rem_sh   = {acc[2*W-1:W], acc[W-1]};
    fits     = rem_sh >= {1'b0, b_q};
    rem_diff = rem_sh[W-1:0] - b_q;
    if (div_q)
      acc_next = {(fits ? rem_diff : rem_sh[W-1:0]), acc[W-2:0], fits};
    else
      acc_next = {mul_sum, acc[W-1:1]};
  end

  assign busy   = (count != '0);
  assign done   = busy && (count == CW'(1)) && !abort;
  assign result = hi_q ? acc_next[2*W-1:W] : acc_next[W-1:0];
  assign div0   = div_q && (b_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      acc   <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      hi_q  <= 1'b0;
    end else if (abort) begin
      count <= '0;
    end else if (go) begin
      count <= CW'(W);
      acc   <= {{W{1'b0}}, a};
      b_q   <= b;
      div_q <= is_div;
      hi_q  <= hi_sel;
    end else if (busy) begin
      count <= count - CW'(1);
      acc   <= acc_next;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered, handshaked RV32-style ALU: single-cycle ops finish next cycle,
// MUL/MULHU/DIVU/REMU run DATA_WIDTH steps on the iterative unit.
//  state | meaning
//  IDLE  | waiting, ready for a new op
//  MUL   | multiply stepping
//  DIV   | divide stepping
//  DONE  | valid_o pulse, can accept the next op
import multicycle_alu_pkg::*;

module multicycle_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = 5,
  parameter int LUI_SHIFT  = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  input  logic                  abort_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o,
  output logic                  Div0_o
);

  state_t                  state, state_next;
  logic                    accept;
  logic [SHAMT_W-1:0]      shamt;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    md_go, md_busy, md_done, md_div0;
  logic [DATA_WIDTH-1:0]   md_result;
  logic                    div0_q;

  assign ready_o = (state == ST_IDLE) || (state == ST_DONE);
  assign valid_o = (state == ST_DONE);
  assign accept  = start_i && ready_o && !abort_i;
  assign md_go   = accept && is_iter(ALU_Operation_i);
  assign shamt   = B_i[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (ALU_Operation_i)
      OP_ADD:  alu_res = A_i + B_i;
      OP_SUB:  alu_res = A_i - B_i;
      OP_XOR:  alu_res = A_i ^ B_i;
      OP_OR:   alu_res = A_i | B_i;
      OP_AND:  alu_res = A_i & B_i;
      OP_SLL:  alu_res = A_i << shamt;
      OP_SRA:  alu_res = $unsigned($signed(A_i) >>> shamt);
      OP_SRL:  alu_res = A_i >> shamt;
      OP_ORI:  alu_res = A_i | B_i;
      OP_LUI:  alu_res = B_i << LUI_SHIFT;
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(A_i) < $signed(B_i)};
      OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, A_i < B_i};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (abort_i || !accept)
          state_next = ST_IDLE;
        else if (is_iter(ALU_Operation_i))
          state_next = ALU_Operation_i[1] ? ST_DIV : ST_MUL;
        else
          state_next = ST_DONE;
      end
      ST_MUL, ST_DIV: begin
        if (abort_i || !md_busy)
          state_next = ST_IDLE;
        else if (md_done)
          state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Result and flags change only on completion; abort leaves them untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ALU_Result_o <= '0;
      div0_q       <= 1'b0;
    end else if (accept && !is_iter(ALU_Operation_i)) begin
      ALU_Result_o <= alu_res;
      div0_q       <= 1'b0;
    end else if ((state == ST_MUL || state == ST_DIV) && md_done) begin
      ALU_Result_o <= md_result;
      div0_q       <= md_div0;
    end
  end

  assign Zero_o = (ALU_Result_o == '0);
  assign Div0_o = div0_q;

  multicycle_alu_muldiv_iter #(.W(DATA_WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .go     (md_go),
    .abort  (abort_i),
    .is_div (ALU_Operation_i[1]),
    .hi_sel (ALU_Operation_i[0]),
    .a      (A_i),
    .b      (B_i),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result),
    .div0   (md_div0)
  );

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: directed corner cases plus random ops checked
// against an arithmetic reference model.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready_o, valid_o, Zero_o, Div0_o;
  logic [31:0] ALU_Result_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_alu #(.DATA_WIDTH(32), .SHAMT_W(5), .LUI_SHIFT(12)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .ALU_Operation_i (op),
    .A_i             (a),
    .B_i             (b),
    .abort_i         (abort_i),
    .ready_o         (ready_o),
    .valid_o         (valid_o),
    .ALU_Result_o    (ALU_Result_o),
    .Zero_o          (Zero_o),
    .Div0_o          (Div0_o)
  );

  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    logic signed [31:0] sx;
    int sh;
    p  = {32'd0, x} * {32'd0, y};
    sx = x;
    sh = int'(y % 32);
    case (o)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x ^ y;
      4'd3:  return x | y;
      4'd4:  return x & y;
      4'd5:  return x << sh;
      4'd6:  return 32'(sx >>> sh);
      4'd7:  return x >> sh;
      4'd8:  return x | y;
      4'd9:  return y * 32'd4096;
      4'd10: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd11: return (x < y) ? 32'd1 : 32'd0;
      4'd12: return p[31:0];
      4'd13: return p[63:32];
      4'd14: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Waits for valid_o from the cycle after accept; returns cycles counted from accept.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_o && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat;
    logic [31:0] er;
    int el;
    er = model(o, x, y);
    el = (o >= 4'd12) ? 33 : 1;
    @(negedge clk);
    op = o; a = x; b = y; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    a = $urandom; b = $urandom;
    wait_valid(lat);
    chk({tag, " latency"}, 32'(lat), 32'(el));
    chk({tag, " result"}, ALU_Result_o, er);
    chk({tag, " zero"}, 32'(Zero_o), 32'(er == 0));
    chk({tag, " div0"}, 32'(Div0_o), 32'((o >= 4'd14) && (y == 0)));
  endtask

  initial begin
    int lat;
    int vcount;
    logic [3:0] ro;
    logic [31:0] rx, ry;

    repeat (2) @(negedge clk);
    chk("rst ready", 32'(ready_o), 32'd1);
    chk("rst valid", 32'(valid_o), 32'd0);
    chk("rst result", ALU_Result_o, 32'd0);
    chk("rst zero", 32'(Zero_o), 32'd1);
    chk("rst div0", 32'(Div0_o), 32'd0);
    reset = 1'b1;

    run_op("add ovf", 4'd0, 32'h7FFF_FFFF, 32'd1);
    chk("add ovf const", ALU_Result_o, 32'h8000_0000);
    run_op("sub zero", 4'd1, 32'd5, 32'd5);
    chk("sub zero flag", 32'(Zero_o), 32'd1);
    run_op("sra", 4'd6, 32'h8000_0000, 32'h21);
    chk("sra const", ALU_Result_o, 32'hC000_0000);
    run_op("slt", 4'd10, 32'hFFFF_FFFF, 32'd1);
    chk("slt const", ALU_Result_o, 32'd1);
    run_op("sltu", 4'd11, 32'hFFFF_FFFF, 32'd1);
    run_op("lui", 4'd9, 32'h1234_5678, 32'h000A_BCDE);
    chk("lui const", ALU_Result_o, 32'hABCD_E000);
    run_op("mul", 4'd12, 32'hFFFF_FFFF, 32'd2);
    chk("mul const", ALU_Result_o, 32'hFFFF_FFFE);
    run_op("mulhu", 4'd13, 32'hFFFF_FFFF, 32'd2);
    chk("mulhu const", ALU_Result_o, 32'd1);
    run_op("divu", 4'd14, 32'd100, 32'd7);
    chk("divu const", ALU_Result_o, 32'd14);
    run_op("remu", 4'd15, 32'd100, 32'd7);
    chk("remu const", ALU_Result_o, 32'd2);
    run_op("divu0", 4'd14, 32'd9, 32'd0);
    chk("divu0 const", ALU_Result_o, 32'hFFFF_FFFF);

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(0, 9));
      run_op("rand", ro, rx, ry);
    end

    // Back-to-back: ADD launched in the DONE cycle of a DIVU.
    @(negedge clk);
    op = 4'd14; a = 32'd100; b = 32'd7; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    wait_valid(lat);
    chk("b2b divu latency", 32'(lat), 32'd33);
    chk("b2b divu result", ALU_Result_o, 32'd14);
    op = 4'd0; a = 32'd3; b = 32'd4; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    chk("b2b add valid", 32'(valid_o), 32'd1);
    chk("b2b add result", ALU_Result_o, 32'd7);

    // start_i while busy is ignored.
    @(negedge clk);
    op = 4'd12; a = 32'd3; b = 32'd5; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    op = 4'd0; a = 32'd1; b = 32'd1; start_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy ready", 32'(ready_o), 32'd0);
    chk("busy result held", ALU_Result_o, 32'd7);
    start_i = 1'b0;
    lat = 8;
    while (!valid_o && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("busy mul latency", 32'(lat), 32'd33);
    chk("busy mul result", ALU_Result_o, 32'd15);

    // Abort a DIVU at step 10.
    @(negedge clk);
    op = 4'd14; a = 32'd1000; b = 32'd3; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    abort_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort ready", 32'(ready_o), 32'd1);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) vcount++;
      @(negedge clk);
    end
    chk("abort no valid", 32'(vcount), 32'd0);
    chk("abort result held", ALU_Result_o, 32'd15);

    // abort_i and start_i together in IDLE: nothing accepted.
    op = 4'd0; a = 32'd40; b = 32'd2; start_i = 1'b1; abort_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    chk("abort+start valid", 32'(valid_o), 32'd0);
    chk("abort+start result", ALU_Result_o, 32'd15);

    // Reset in the middle of a MUL, with Div0 left set by a prior REMU.
    run_op("remu0", 4'd15, 32'd9, 32'd0);
    chk("remu0 const", ALU_Result_o, 32'd9);
    @(negedge clk);
    op = 4'd12; a = 32'hFFFF_FFFF; b = 32'd2; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst result", ALU_Result_o, 32'd0);
    chk("midrst zero", 32'(Zero_o), 32'd1);
    chk("midrst div0", 32'(Div0_o), 32'd0);
    chk("midrst valid", 32'(valid_o), 32'd0);
    chk("midrst ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    run_op("post rst add", 4'd0, 32'd2, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
